// File: rtl/buffer_exmem_pkg.sv
// Shared widths, control bit positions and buffer state encodings for the
// EX/MEM pipeline buffer.
package buffer_exmem_pkg;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int AW = 4;
  localparam int PW = 3 * DW + AW + CW;

  localparam int CTRL_REGW = 3;
  localparam int CTRL_MEMW = 2;
  localparam int CTRL_MEMR = 1;
  localparam int CTRL_R15W = 0;

  // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  // Payload layout, MSB first: res, res15, store, rd, ctrl.
  function automatic logic [PW-1:0] pack_entry(
    input logic [DW-1:0] res,
    input logic [DW-1:0] res15,
    input logic [DW-1:0] store,
    input logic [AW-1:0] rd,
    input logic [CW-1:0] ctrl
  );
    return {res, res15, store, rd, ctrl};
  endfunction

endpackage

// File: rtl/buffer_exmem_entry_reg.sv
// One EX/MEM payload slot: captures the packed entry on load, clears on reset.
module exmem_entry_reg
  import buffer_exmem_pkg::*;
#(
  parameter int W = PW
) (
  input  logic         C,
  input  logic         R,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Payload capture on load; async clear on reset.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/buffer_exmem.sv
// EX/MEM pipeline buffer: two-slot skid buffer (main + skid) between the EX
// and MEM stages. in_ready depends only on the skid flag and reset, so MEM
// back-pressure never forms a combinational path into EX.
module buffer_exmem
  import buffer_exmem_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic          C,
  input  logic          R,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_res,
  input  logic [DW-1:0] in_res15,
  input  logic [DW-1:0] in_store,
  input  logic [AW-1:0] in_rd,
  input  logic [CW-1:0] in_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic [DW-1:0] out_res15,
  output logic [DW-1:0] out_store,
  output logic [AW-1:0] out_rd,
  output logic [CW-1:0] out_ctrl,
  output logic          fwd_en,
  output logic [AW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic [SW-1:0] stall_cnt
);

  localparam logic [SW-1:0] STALL_MAX = {SW{1'b1}};
  localparam logic [SW-1:0] STALL_ONE = {{(SW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        state_nx_s;
  logic          main_valid_s;
  logic          skid_valid_s;
  logic          accept_s;
  logic          pop_s;
  logic          load_main_s;
  logic          load_skid_s;
  logic          main_from_skid_s;
  logic [PW-1:0] in_entry_s;
  logic [PW-1:0] main_d_s;
  logic [PW-1:0] main_q_s;
  logic [PW-1:0] skid_q_s;
  logic [SW-1:0] stall_cnt_r;

  assign main_valid_s = state_r[0];
  assign skid_valid_s = state_r[1];
  assign in_ready     = ~skid_valid_s & ~R;
  assign accept_s     = in_valid & in_ready;
  assign pop_s        = main_valid_s & out_ready;
  assign in_entry_s   = pack_entry(in_res, in_res15, in_store, in_rd, in_ctrl);

  // State register: occupancy of main and skid slots.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state: flush empties the buffer regardless of handshakes.
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) state_nx_s = ONE;
          else          state_nx_s = EMPTY;
        end
        ONE: begin
          if (accept_s && !pop_s)      state_nx_s = TWO;
          else if (!accept_s && pop_s) state_nx_s = EMPTY;
          else                         state_nx_s = ONE;
        end
        TWO: begin
          if (pop_s) state_nx_s = ONE;
          else       state_nx_s = TWO;
        end
        default: state_nx_s = EMPTY;
      endcase
    end
  end

  // Slot load controls: which slot captures and where main gets its data.
  always_comb begin
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    if (flush) begin
      load_main_s = 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          load_main_s = accept_s;
        end
        ONE: begin
          load_main_s = accept_s & pop_s;
          load_skid_s = accept_s & ~pop_s;
        end
        TWO: begin
          load_main_s      = pop_s;
          main_from_skid_s = pop_s;
        end
        default: begin
          load_main_s = 1'b0;
        end
      endcase
    end
  end

  // Main slot source: the skid entry is older than anything on the input.
  always_comb begin
    main_d_s = in_entry_s;
    if (main_from_skid_s) begin
      main_d_s = skid_q_s;
    end else begin
      main_d_s = in_entry_s;
    end
  end

  exmem_entry_reg #(.W(PW)) u_main (
    .C    (C),
    .R    (R),
    .load (load_main_s),
    .d    (main_d_s),
    .q    (main_q_s)
  );

  exmem_entry_reg #(.W(PW)) u_skid (
    .C    (C),
    .R    (R),
    .load (load_skid_s),
    .d    (in_entry_s),
    .q    (skid_q_s)
  );

  // Saturating count of cycles where MEM holds off a valid entry.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      stall_cnt_r <= {SW{1'b0}};
    end else if (main_valid_s && !out_ready && !flush && (stall_cnt_r != STALL_MAX)) begin
      stall_cnt_r <= stall_cnt_r + STALL_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign {out_res, out_res15, out_store, out_rd, out_ctrl} = main_q_s;
  assign out_valid = main_valid_s;
  assign fwd_en    = main_valid_s & out_ctrl[CTRL_REGW];
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_res;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_buffer_exmem.sv
// Self-checking bench for buffer_exmem: a capacity-2 FIFO model plus
// hand-computed expectations for the directed scenarios.
module tb_buffer_exmem;

  logic        C = 1'b0;
  logic        R = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_res = 16'h0000;
  logic [15:0] in_res15 = 16'h0000;
  logic [15:0] in_store = 16'h0000;
  logic [3:0]  in_rd = 4'h0;
  logic [3:0]  in_ctrl = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_res, out_res15, out_store;
  logic [3:0]  out_rd, out_ctrl;
  logic        fwd_en;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic [7:0]  stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  buffer_exmem #(.SW(8)) dut (
    .C(C), .R(R), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_res15(in_res15), .in_store(in_store),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_res15(out_res15), .out_store(out_store),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  always #5 C = ~C;

  typedef struct {
    logic [15:0] res;
    logic [15:0] res15;
    logic [15:0] store;
    logic [3:0]  rd;
    logic [3:0]  ctrl;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: FIFO of depth 2, flush empties, stall counter saturates.
  always @(posedge C or posedge R) begin : model
    int   sz;
    bit   pop_m;
    bit   acc_m;
    ent_t e;
    if (R) begin
      mq.delete();
      m_stall = 0;
    end else begin
      sz    = mq.size();
      pop_m = (sz > 0) && out_ready;
      acc_m = in_valid && (sz < 2);
      if ((sz > 0) && !out_ready && !flush && (m_stall < 255)) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop_m) void'(mq.pop_front());
        if (acc_m) begin
          e.res = in_res; e.res15 = in_res15; e.store = in_store;
          e.rd = in_rd; e.ctrl = in_ctrl;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge C);
      #1;
      if (R) begin
        chk("rst_in_ready", 32'(in_ready), 32'h0);
      end else begin
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        if (mq.size() > 0) begin
          chk("out_res", 32'(out_res), 32'(mq[0].res));
          chk("out_res15", 32'(out_res15), 32'(mq[0].res15));
          chk("out_store", 32'(out_store), 32'(mq[0].store));
          chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
          chk("out_ctrl", 32'(out_ctrl), 32'(mq[0].ctrl));
          chk("fwd_en", 32'(fwd_en), 32'(mq[0].ctrl[3]));
          chk("fwd_rd", 32'(fwd_rd), 32'(mq[0].rd));
          chk("fwd_data", 32'(fwd_data), 32'(mq[0].res));
        end else begin
          chk("fwd_en_idle", 32'(fwd_en), 32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge C);
    #2;
  endtask

  task automatic set_in(input logic v, input logic [15:0] res, input logic [3:0] rd, input logic [3:0] ctrl);
    in_valid = v;
    in_res   = res;
    in_res15 = ~res;
    in_store = res ^ 16'h5A5A;
    in_rd    = rd;
    in_ctrl  = ctrl;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("lit_rst_out_valid", 32'(out_valid), 32'h0);
    chk("lit_rst_in_ready", 32'(in_ready), 32'h0);
    chk("lit_rst_stall", 32'(stall_cnt), 32'h0);
    chk("lit_rst_fwd_en", 32'(fwd_en), 32'h0);
    R = 1'b0;
    tick();
    chk("lit_ready_after_rst", 32'(in_ready), 32'h1);

    // 1: single entry, one-cycle latency
    out_ready = 1'b1;
    set_in(1'b1, 16'h0A01, 4'h3, 4'h8);
    tick();
    set_in(1'b0, 16'h0000, 4'h0, 4'h0);
    chk("lit_t1_valid", 32'(out_valid), 32'h1);
    chk("lit_t1_res", 32'(out_res), 32'h0A01);
    chk("lit_t1_fwd_en", 32'(fwd_en), 32'h1);
    chk("lit_t1_fwd_rd", 32'(fwd_rd), 32'h3);
    tick();
    chk("lit_t1_drained", 32'(out_valid), 32'h0);

    // 2: back-to-back streaming 1..5
    for (int i = 1; i <= 5; i++) begin
      set_in(1'b1, 16'(i), 4'(i), 4'(i + 6));
      tick();
      chk("lit_t2_res", 32'(out_res), 32'(i));
      chk("lit_t2_ready", 32'(in_ready), 32'h1);
    end
    set_in(1'b0, 16'h0000, 4'h0, 4'h0);
    tick();
    chk("lit_t2_drained", 32'(out_valid), 32'h0);

    // 3: MEM stall fills the skid slot
    out_ready = 1'b0;
    set_in(1'b1, 16'h00B3, 4'h5, 4'h9);
    tick();
    chk("lit_t3_ready1", 32'(in_ready), 32'h1);
    chk("lit_t3_stall0", 32'(stall_cnt), 32'h0);
    set_in(1'b1, 16'hFFF0, 4'h6, 4'h4);
    tick();
    set_in(1'b0, 16'h0000, 4'h0, 4'h0);
    chk("lit_t3_full", 32'(in_ready), 32'h0);
    chk("lit_t3_head", 32'(out_res), 32'h00B3);
    chk("lit_t3_stall1", 32'(stall_cnt), 32'h1);
    tick();
    chk("lit_t3_stall2", 32'(stall_cnt), 32'h2);
    out_ready = 1'b1;
    tick();
    chk("lit_t3_pop2", 32'(out_res), 32'hFFF0);
    chk("lit_t3_ready_back", 32'(in_ready), 32'h1);
    tick();
    chk("lit_t3_drained", 32'(out_valid), 32'h0);

    // 4: flush with two entries and a concurrent push
    out_ready = 1'b0;
    set_in(1'b1, 16'h1111, 4'h1, 4'h8);
    tick();
    set_in(1'b1, 16'h2222, 4'h2, 4'h8);
    tick();
    chk("lit_t4_full", 32'(in_ready), 32'h0);
    flush = 1'b1;
    set_in(1'b1, 16'h200F, 4'h7, 4'h8);
    tick();
    flush = 1'b0;
    set_in(1'b0, 16'h0000, 4'h0, 4'h0);
    chk("lit_t4_empty", 32'(out_valid), 32'h0);
    chk("lit_t4_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_t4_no_200f", 32'(out_valid), 32'h0);
    end

    // 5: async reset pulse between edges while full
    out_ready = 1'b0;
    set_in(1'b1, 16'hAAAA, 4'h9, 4'h8);
    tick();
    set_in(1'b1, 16'hBBBB, 4'hA, 4'h8);
    tick();
    set_in(1'b0, 16'h0000, 4'h0, 4'h0);
    tick();
    chk("lit_t5_full", 32'(in_ready), 32'h0);
    #1 R = 1'b1;
    #1;
    chk("lit_t5_valid", 32'(out_valid), 32'h0);
    chk("lit_t5_fwd", 32'(fwd_en), 32'h0);
    chk("lit_t5_stall", 32'(stall_cnt), 32'h0);
    chk("lit_t5_ready", 32'(in_ready), 32'h0);
    R = 1'b0;
    tick();
    chk("lit_t5_quiet", 32'(out_valid), 32'h0);

    // 6: stall counter saturation
    set_in(1'b1, 16'hC3C3, 4'hC, 4'h8);
    tick();
    set_in(1'b0, 16'h0000, 4'h0, 4'h0);
    repeat (300) tick();
    chk("lit_t6_sat", 32'(stall_cnt), 32'hFF);
    repeat (5) tick();
    chk("lit_t6_hold", 32'(stall_cnt), 32'hFF);
    chk("lit_t6_head", 32'(out_res), 32'hC3C3);
    out_ready = 1'b1;
    tick();
    chk("lit_t6_drained", 32'(out_valid), 32'h0);
    chk("lit_t6_keep", 32'(stall_cnt), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
